traffic_light_sequencer: RTL and testbench
==========================================

// Module: traffic_light_sequencer
// PURPOSE
//  Consumer of the 2-bit traffic mode register: turns the registered mode into main/side lamp and walk outputs.
//  Mode encoding: 00 night, 01 day, 10 pedestrian, 11 emergency.
//  Timed FSM plus down-counter; sits directly downstream of the traffic-mode DFF, same clock domain.
// PARAMETERS
//  CNT_W         8   phase counter width; every *_TICKS must be in 1..2^CNT_W-1
//  GREEN_TICKS   8   cycles a green phase lasts
//  YELLOW_TICKS  3   cycles a yellow phase lasts
//  ALLRED_TICKS  2   cycles an all-red clearance phase lasts
//  WALK_TICKS    6   cycles the walk phase lasts
//  FLASH_TICKS   4   cycles between lamp toggles in night flash
// PORTS
//  clk          in   1  system clock, posedge
//  rst          in   1  synchronous reset, active-high
//  trafficMode  in   2  registered mode (00 night, 01 day, 10 ped, 11 emg)
//  mainLight    out  3  main-street lamps {R,Y,G}
//  sideLight    out  3  side-street lamps {R,Y,G}
//  walk         out  1  pedestrian walk lamp
//  phase        out  4  current FSM state, for debug
// BEHAVIOUR
//  States: MAIN_G=0, MAIN_Y=1, RED_A=2, SIDE_G=3, SIDE_Y=4, RED_B=5, WALK=6, FLASH=7, EMG=8.
//  Outputs are registered.
//    Lamps by state: G=001, Y=010, R=100; the non-active street shows R.
//    RED_A, RED_B, WALK and EMG: both streets 100.
//    walk=1 only in WALK.
//  Reset: phase=RED_A, cnt=ALLRED_TICKS-1, mainLight=sideLight=100, walk=0, blink=1, ped latch cleared.
//  Timing:
//    On entering a timed state, cnt loads TICKS-1; cnt decrements each cycle.
//    A state exits on the cycle cnt==0, so it lasts exactly TICKS cycles.
//  Normal (day) loop: MAIN_G->MAIN_Y->RED_A->SIDE_G->SIDE_Y->RED_B->MAIN_G.
//    Full loop = 2*(G+Y+AR) = 26 cycles at default parameters.
//  All-red expiry (RED_A/RED_B, cnt==0) picks the next state, in priority order:
//    emg -> EMG; ped request -> WALK; mode 00 -> FLASH; else the next state of the normal loop.
//  WALK: lasts WALK_TICKS, then goes to RED_B (full count); main street is served next.
//  Emergency (mode 11) is sampled every cycle and takes effect on the next edge:
//    MAIN_G -> MAIN_Y, and SIDE_G -> SIDE_Y, both with a fresh YELLOW_TICKS count.
//    A yellow phase already running finishes its count, then goes to EMG.
//    RED_A, RED_B, WALK and FLASH go to EMG immediately.
//    EMG holds while mode==11; on exit -> RED_A with a full count.
//  FLASH:
//    blink=1 on entry and toggles every FLASH_TICKS cycles.
//    mainLight={0,blink,0}; sideLight={blink,0,0}.
//    Any mode other than 00 -> RED_A with a full count (11 -> EMG instead).
//  Mode changes between 00/01/10 never cut a green or yellow short.
//    They are acted on only at all-red expiry or when leaving FLASH.
//  Simultaneous events: emergency beats ped, ped beats night.
//    A pending ped request survives an EMG episode.
//  rst mid-operation: overrides everything on the next edge and returns to the reset state.
// CONFIGURATION
//  TLS_PED_LATCH_EN defined:
//    pedPending sets on any cycle with mode==10 and clears on entry to WALK or on rst.
//    The ped request is (mode==10 | pedPending).
//  TLS_PED_LATCH_EN undefined: no latch; the ped request is mode==10 sampled on the all-red expiry cycle only.
// TESTING
//  1. rst=1 for 2 cycles, then mode=01 -> 100/100, walk=0.
//     Then RED_A 2 cycles, SIDE_G 8, SIDE_Y 3, RED_B 2, MAIN_G 8; the loop repeats every 26 cycles.
//  2. mode=10 held from MAIN_G -> MAIN_Y 3 cycles, RED_A 2, then walk=1 for exactly 6 cycles with 100/100.
//     Then RED_B 2 cycles, then MAIN_G (001).
//  3. mode=11 raised in MAIN_G with cnt=5 -> next edge mainLight=010 for 3 cycles, then EMG 100/100 held.
//     mode=01 -> RED_A 2 cycles, then SIDE_G.
//  4. mode=00 -> at the next all-red expiry, FLASH: mainLight 010/000 and sideLight 100/000, toggling every 4 cycles.
//     mode=01 -> RED_A 100/100 for 2 cycles.
//  5. One-cycle mode=10 pulse during MAIN_G.
//     With TLS_PED_LATCH_EN: WALK follows RED_A.
//     Without it: SIDE_G follows RED_A and walk stays 0.
//  6. rst=1 on the 3rd cycle of WALK -> next edge: walk=0, 100/100, phase=2.
//     pedPending=0, so no second WALK.

Source files
------------

// File: rtl/traffic_light_sequencer.sv
// -----------------------------------------------------------------------------
// traffic_light_sequencer
//
// Turns the registered 2-bit traffic mode (00 night, 01 day, 10 pedestrian,
// 11 emergency) into main/side street lamps and a pedestrian walk lamp.
// A timed FSM with a shared down-counter sequences the phases; every output
// is a flop, loaded from the decode of the next state.
//
// Ports:
//   clk          in   1  system clock, rising edge
//   rst          in   1  synchronous reset, active-high
//   trafficMode  in   2  registered mode (00 night, 01 day, 10 ped, 11 emg)
//   mainLight    out  3  main-street lamps {R,Y,G}
//   sideLight    out  3  side-street lamps {R,Y,G}
//   walk         out  1  pedestrian walk lamp
//   phase        out  4  current FSM state, for debug
//
// Configuration macro:
//   TLS_PED_LATCH_EN  when defined, a pedestrian request is latched on any
//                     cycle with mode 10 and held until WALK is entered (or
//                     rst). When undefined, mode 10 is only honoured if it
//                     is present on the cycle an all-red phase expires.
// -----------------------------------------------------------------------------
module traffic_light_sequencer #(
    parameter int CNT_W        = 8,
    parameter int GREEN_TICKS  = 8,
    parameter int YELLOW_TICKS = 3,
    parameter int ALLRED_TICKS = 2,
    parameter int WALK_TICKS   = 6,
    parameter int FLASH_TICKS  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] trafficMode,
    output logic [2:0] mainLight,
    output logic [2:0] sideLight,
    output logic       walk,
    output logic [3:0] phase
);

    typedef enum logic [3:0] {
        MAIN_G = 4'd0,
        MAIN_Y = 4'd1,
        RED_A  = 4'd2,
        SIDE_G = 4'd3,
        SIDE_Y = 4'd4,
        RED_B  = 4'd5,
        WALK   = 4'd6,
        FLASH  = 4'd7,
        EMG    = 4'd8
    } state_t;

    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [CNT_W-1:0] WALK_LOAD   = CNT_W'(WALK_TICKS - 1);
    localparam logic [CNT_W-1:0] FLASH_LOAD  = CNT_W'(FLASH_TICKS - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             blink;
    logic             blink_next;
    // Set while RED_B is the clearance that follows WALK: the main street
    // must be served next, whatever the mode says.
    logic             after_walk;
    logic             after_walk_next;

    logic             cnt_zero;
    logic             emg;
    logic             night;
    logic             ped_req;

    logic [2:0]       main_next;
    logic [2:0]       side_next;
    logic             walk_next;

    always_comb begin
        cnt_zero = (cnt == '0);
        emg      = (trafficMode == 2'b11);
        night    = (trafficMode == 2'b00);
    end

`ifdef TLS_PED_LATCH_EN
    logic ped_pending;
    logic ped_pending_next;

    always_comb begin
        ped_req          = (trafficMode == 2'b10) | ped_pending;
        ped_pending_next = ped_pending | (trafficMode == 2'b10);
        // Entering WALK serves the request; clearing wins over a same-cycle set.
        if (state_next == WALK && state != WALK) begin
            ped_pending_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ped_pending <= 1'b0;
        end else begin
            ped_pending <= ped_pending_next;
        end
    end
`else
    always_comb begin
        ped_req = (trafficMode == 2'b10);
    end
`endif

    // Next-state, counter and blink logic.
    always_comb begin
        state_next      = state;
        cnt_next        = cnt - CNT_ONE;
        blink_next      = 1'b1;
        after_walk_next = 1'b0;

        unique case (state)
            MAIN_G, SIDE_G: begin
                // Emergency cuts a green short into a fresh yellow.
                if (emg || cnt_zero) begin
                    state_next = (state == MAIN_G) ? MAIN_Y : SIDE_Y;
                    cnt_next   = YELLOW_LOAD;
                end
            end

            MAIN_Y, SIDE_Y: begin
                // A running yellow always completes its count.
                if (cnt_zero) begin
                    if (emg) begin
                        state_next = EMG;
                        cnt_next   = '0;
                    end else begin
                        state_next = (state == MAIN_Y) ? RED_A : RED_B;
                        cnt_next   = ALLRED_LOAD;
                    end
                end
            end

            RED_A, RED_B: begin
                if (emg) begin
                    state_next = EMG;
                    cnt_next   = '0;
                end else if (cnt_zero) begin
                    if (state == RED_B && after_walk) begin
                        state_next = MAIN_G;
                        cnt_next   = GREEN_LOAD;
                    end else if (ped_req) begin
                        state_next = WALK;
                        cnt_next   = WALK_LOAD;
                    end else if (night) begin
                        state_next = FLASH;
                        cnt_next   = FLASH_LOAD;
                    end else begin
                        state_next = (state == RED_A) ? SIDE_G : MAIN_G;
                        cnt_next   = GREEN_LOAD;
                    end
                end else begin
                    after_walk_next = after_walk;
                end
            end

            WALK: begin
                if (emg) begin
                    state_next = EMG;
                    cnt_next   = '0;
                end else if (cnt_zero) begin
                    state_next      = RED_B;
                    cnt_next        = ALLRED_LOAD;
                    after_walk_next = 1'b1;
                end
            end

            FLASH: begin
                if (emg) begin
                    state_next = EMG;
                    cnt_next   = '0;
                end else if (!night) begin
                    state_next = RED_A;
                    cnt_next   = ALLRED_LOAD;
                end else if (cnt_zero) begin
                    blink_next = ~blink;
                    cnt_next   = FLASH_LOAD;
                end else begin
                    blink_next = blink;
                end
            end

            EMG: begin
                cnt_next = '0;
                if (!emg) begin
                    state_next = RED_A;
                    cnt_next   = ALLRED_LOAD;
                end
            end

            default: begin
                state_next = RED_A;
                cnt_next   = ALLRED_LOAD;
            end
        endcase
    end

    // Lamp decode of the next state, so the registered lamps line up with phase.
    always_comb begin
        main_next = LAMP_R;
        side_next = LAMP_R;
        walk_next = 1'b0;

        unique case (state_next)
            MAIN_G:  main_next = LAMP_G;
            MAIN_Y:  main_next = LAMP_Y;
            SIDE_G:  side_next = LAMP_G;
            SIDE_Y:  side_next = LAMP_Y;
            WALK:    walk_next = 1'b1;
            FLASH: begin
                main_next = {1'b0, blink_next, 1'b0};
                side_next = {blink_next, 2'b00};
            end
            default: begin
                main_next = LAMP_R;
                side_next = LAMP_R;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RED_A;
            cnt        <= ALLRED_LOAD;
            blink      <= 1'b1;
            after_walk <= 1'b0;
            mainLight  <= LAMP_R;
            sideLight  <= LAMP_R;
            walk       <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            blink      <= blink_next;
            after_walk <= after_walk_next;
            mainLight  <= main_next;
            sideLight  <= side_next;
            walk       <= walk_next;
        end
    end

    always_comb begin
        phase = state;
    end

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_sequencer
//
// Directed scenarios with literal expectations, followed by randomized mode
// and reset stimulus. A phase/elapsed-time model of the lamp rules predicts
// every output on every cycle.
// -----------------------------------------------------------------------------
module tb_traffic_light_sequencer;

    localparam int G  = 8;
    localparam int Y  = 3;
    localparam int AR = 2;
    localparam int W  = 6;
    localparam int F  = 4;

`ifdef TLS_PED_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    // Phase codes as numbered by the design's debug output.
    localparam int P_MG = 0, P_MY = 1, P_RA = 2, P_SG = 3, P_SY = 4;
    localparam int P_RB = 5, P_WK = 6, P_FL = 7, P_EM = 8;

    logic       clk;
    logic       rst;
    logic [1:0] trafficMode;
    logic [2:0] mainLight;
    logic [2:0] sideLight;
    logic       walk;
    logic [3:0] phase;

    int checks = 0;
    int errors = 0;

    traffic_light_sequencer #(
        .CNT_W        (8),
        .GREEN_TICKS  (G),
        .YELLOW_TICKS (Y),
        .ALLRED_TICKS (AR),
        .WALK_TICKS   (W),
        .FLASH_TICKS  (F)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .trafficMode (trafficMode),
        .mainLight   (mainLight),
        .sideLight   (sideLight),
        .walk        (walk),
        .phase       (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // The model tracks which phase is showing and how many cycles it has shown.
    int m_ph;
    int m_el;
    bit m_from_walk;
    bit m_pend;
    bit m_valid = 1'b0;

    function automatic int dur(input int ph);
        case (ph)
            P_MG, P_SG: return G;
            P_MY, P_SY: return Y;
            P_RA, P_RB: return AR;
            P_WK:       return W;
            default:    return 1;
        endcase
    endfunction

    function automatic logic [2:0] exp_main(input int ph, input int el);
        bit on;
        on = ((el / F) % 2) == 0;
        case (ph)
            P_MG:    return 3'b001;
            P_MY:    return 3'b010;
            P_FL:    return on ? 3'b010 : 3'b000;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] exp_side(input int ph, input int el);
        bit on;
        on = ((el / F) % 2) == 0;
        case (ph)
            P_SG:    return 3'b001;
            P_SY:    return 3'b010;
            P_FL:    return on ? 3'b100 : 3'b000;
            default: return 3'b100;
        endcase
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int  nph;
        bit  emg, night, ped, expiring;
        if (m_valid) begin
            cmp("model_phase", int'(phase), m_ph);
            cmp("model_main",  int'(mainLight), int'(exp_main(m_ph, m_el)));
            cmp("model_side",  int'(sideLight), int'(exp_side(m_ph, m_el)));
            cmp("model_walk",  int'(walk), (m_ph == P_WK) ? 1 : 0);
        end
        // Advance the model with the inputs the coming rising edge will see.
        if (rst) begin
            m_ph        = P_RA;
            m_el        = 0;
            m_from_walk = 1'b0;
            m_pend      = 1'b0;
            m_valid     = 1'b1;
        end else if (m_valid) begin
            emg      = (trafficMode == 2'b11);
            night    = (trafficMode == 2'b00);
            ped      = (trafficMode == 2'b10) || (LATCH && m_pend);
            expiring = (m_el >= dur(m_ph) - 1);
            nph      = m_ph;
            case (m_ph)
                P_MG, P_SG: if (emg || expiring) nph = m_ph + 1;
                P_MY, P_SY: if (expiring) nph = emg ? P_EM : m_ph + 1;
                P_RA, P_RB: begin
                    if (emg) nph = P_EM;
                    else if (expiring) begin
                        if (m_ph == P_RB && m_from_walk) nph = P_MG;
                        else if (ped)                    nph = P_WK;
                        else if (night)                  nph = P_FL;
                        else                             nph = (m_ph == P_RA) ? P_SG : P_MG;
                    end
                end
                P_WK: if (emg) nph = P_EM; else if (expiring) nph = P_RB;
                P_FL: if (emg) nph = P_EM; else if (!night) nph = P_RA;
                default: if (!emg) nph = P_RA;
            endcase
            if (m_ph == P_WK && nph == P_RB) m_from_walk = 1'b1;
            else if (!(m_ph == P_RB && nph == P_RB)) m_from_walk = 1'b0;
            if (LATCH) begin
                if (trafficMode == 2'b10) m_pend = 1'b1;
                if (nph == P_WK && m_ph != P_WK) m_pend = 1'b0;
            end
            m_el = (nph == m_ph) ? m_el + 1 : 0;
            m_ph = nph;
        end
    end

    // ---------------- directed literal checks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input int ph, input int ml, input int sl, input int wk);
        cmp({name, "_phase"}, int'(phase), ph);
        cmp({name, "_main"},  int'(mainLight), ml);
        cmp({name, "_side"},  int'(sideLight), sl);
        cmp({name, "_walk"},  int'(walk), wk);
    endtask

    initial begin
        int hold;
        int r;
        rst         = 1'b1;
        trafficMode = 2'b01;
        tick(2);
        rst = 1'b0;
        // 1: day loop from reset
        lit("t1_reset",  P_RA, 'b100, 'b100, 0);
        tick(2);  lit("t1_sideg", P_SG, 'b100, 'b001, 0);
        tick(8);  lit("t1_sidey", P_SY, 'b100, 'b010, 0);
        tick(3);  lit("t1_redb",  P_RB, 'b100, 'b100, 0);
        tick(2);  lit("t1_maing", P_MG, 'b001, 'b100, 0);
        // 2: pedestrian mode held from MAIN_G
        trafficMode = 2'b10;
        tick(8);  lit("t2_mainy", P_MY, 'b010, 'b100, 0);
        tick(3);  lit("t2_reda",  P_RA, 'b100, 'b100, 0);
        tick(2);  lit("t2_walk",  P_WK, 'b100, 'b100, 1);
        trafficMode = 2'b01;
        tick(5);  lit("t2_walk6", P_WK, 'b100, 'b100, 1);
        tick(1);  lit("t2_redb",  P_RB, 'b100, 'b100, 0);
        tick(2);  lit("t2_maing", P_MG, 'b001, 'b100, 0);
        // 3: emergency raised in MAIN_G with two cycles of green elapsed
        tick(2);
        trafficMode = 2'b11;
        tick(1);  lit("t3_mainy",  P_MY, 'b010, 'b100, 0);
        tick(2);  lit("t3_mainy3", P_MY, 'b010, 'b100, 0);
        tick(1);  lit("t3_emg",    P_EM, 'b100, 'b100, 0);
        tick(5);  lit("t3_emgh",   P_EM, 'b100, 'b100, 0);
        trafficMode = 2'b01;
        tick(1);  lit("t3_reda",   P_RA, 'b100, 'b100, 0);
        tick(1);  lit("t3_reda2",  P_RA, 'b100, 'b100, 0);
        tick(1);  lit("t3_sideg",  P_SG, 'b100, 'b001, 0);
        // 4: night flash at the next all-red expiry
        trafficMode = 2'b00;
        tick(8);  lit("t4_sidey",  P_SY, 'b100, 'b010, 0);
        tick(3);  lit("t4_redb",   P_RB, 'b100, 'b100, 0);
        tick(2);  lit("t4_flon",   P_FL, 'b010, 'b100, 0);
        tick(3);  lit("t4_flon4",  P_FL, 'b010, 'b100, 0);
        tick(1);  lit("t4_floff",  P_FL, 'b000, 'b000, 0);
        tick(3);  lit("t4_floff4", P_FL, 'b000, 'b000, 0);
        tick(1);  lit("t4_flon2",  P_FL, 'b010, 'b100, 0);
        trafficMode = 2'b01;
        tick(1);  lit("t4_reda",   P_RA, 'b100, 'b100, 0);
        tick(2);  lit("t4_sideg",  P_SG, 'b100, 'b001, 0);
        // 5: one-cycle pedestrian pulse during MAIN_G
        tick(13); lit("t5_maing",  P_MG, 'b001, 'b100, 0);
        trafficMode = 2'b10;
        tick(1);
        trafficMode = 2'b01;
        tick(7);  lit("t5_mainy",  P_MY, 'b010, 'b100, 0);
        tick(3);  lit("t5_reda",   P_RA, 'b100, 'b100, 0);
        tick(2);  lit("t5_after",  LATCH ? P_WK : P_SG, 'b100, LATCH ? 'b100 : 'b001, LATCH ? 1 : 0);
        // 6: reset in the third cycle of WALK
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        trafficMode = 2'b10;
        tick(2);  lit("t6_walk",   P_WK, 'b100, 'b100, 1);
        tick(1);
        trafficMode = 2'b01;
        tick(1);  lit("t6_walk3",  P_WK, 'b100, 'b100, 1);
        rst = 1'b1;
        tick(1);  lit("t6_rst",    P_RA, 'b100, 'b100, 0);
        rst = 1'b0;
        tick(2);  lit("t6_sideg",  P_SG, 'b100, 'b001, 0);

        // ---------------- randomized section ----------------
        hold = 0;
        repeat (4000) begin
            if (hold == 0) begin
                r = $urandom_range(0, 99);
                if (r < 10)      trafficMode = 2'b00;
                else if (r < 55) trafficMode = 2'b01;
                else if (r < 80) trafficMode = 2'b10;
                else             trafficMode = 2'b11;
                hold = ($urandom_range(0, 9) == 0) ? 1 : $urandom_range(1, 40);
            end
            hold--;
            rst = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        rst = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
